// File: rtl/ddr2_arb_pkg.sv
// Shared constants for the two-port DDR2 command arbiter: command codes,
// FSM state encodings and the outstanding-read tag width.
package ddr2_arb_pkg;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WBURST = 2'd1;
    localparam logic [1:0] S_RADDR  = 2'd2;

    localparam int TAG_DEPTH_DEF = 16;

    function automatic int tag_w(input int depth);
        return $clog2(depth);
    endfunction

    localparam int TAG_W = tag_w(TAG_DEPTH_DEF);

endpackage

// File: rtl/ddr2_port_arbiter_0_tag_fifo.sv
// In-order requester-id FIFO for outstanding reads; one bit wide, DEPTH deep,
// pointers wrap modulo DEPTH (DEPTH must be a power of two).
module ddr2_tag_fifo_0
    import ddr2_arb_pkg::*;
#(
    parameter int DEPTH = TAG_DEPTH_DEF,
    parameter int AW    = tag_w(DEPTH)
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot the push needs
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr2_port_arbiter_0.sv
// Two-port arbiter in front of the DDR2 app_af/app_wdf FIFOs with in-order read
// steering. Define DDR2_ARB_FIXED_PRIO_EN for fixed priority (req0 wins), else round-robin.
//   state    | meaning
//   S_IDLE   | waiting for an issuable request
//   S_WBURST | streaming write beats, address written with the last beat
//   S_RADDR  | writing read address and pushing the requester tag
module ddr2_port_arbiter_0
    import ddr2_arb_pkg::*;
#(
    parameter int ADDR_W    = 36,
    parameter int DATA_W    = 144,
    parameter int MASK_W    = 18,
    parameter int TAG_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_done,
    input  logic              af_almost_full,
    input  logic              wdf_almost_full,
    input  logic [2:0]        burst_length_div2,
    input  logic              req0_valid,
    input  logic              req0_rd,
    input  logic [31:0]       req0_addr,
    output logic              req0_ack,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [MASK_W-1:0] req0_wmask,
    output logic              req0_wbeat,
    input  logic              req1_valid,
    input  logic              req1_rd,
    input  logic [31:0]       req1_addr,
    output logic              req1_ack,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic [MASK_W-1:0] req1_wmask,
    output logic              req1_wbeat,
    output logic [ADDR_W-1:0] app_af_addr,
    output logic              app_af_wren,
    output logic [DATA_W-1:0] app_wdf_data,
    output logic [MASK_W-1:0] app_mask_data,
    output logic              app_wdf_wren,
    input  logic              read_data_valid,
    input  logic [DATA_W-1:0] read_data_fifo_out,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid0,
    output logic              rd_valid1,
    output logic              tag_overflow
);

    logic        rst_q;
    logic        wdf_af_q;
    logic [1:0]  state;
    logic        sel_q;
    logic [31:0] addr_q;
    logic [2:0]  wcnt;
    logic [2:0]  rcnt;
`ifndef DDR2_ARB_FIXED_PRIO_EN
    logic        rr_ptr;
`endif

    logic        issue_ok;
    logic        pick1;
    logic        gnt_any;
    logic        beat_go;
    logic        ret_go;
    logic        tag_push;
    logic        tag_pop;
    logic        tag_head;
    logic        tag_full;
    logic        tag_empty;

    always_ff @(posedge clk) begin
        rst_q    <= reset;
        wdf_af_q <= wdf_almost_full;
    end

    always_comb begin
        issue_ok = (state == S_IDLE) && !rst_q && init_done && !wdf_af_q
                   && !af_almost_full && !tag_full;
`ifdef DDR2_ARB_FIXED_PRIO_EN
        pick1 = !req0_valid;
`else
        pick1 = req1_valid && (!req0_valid || rr_ptr);
`endif
        gnt_any  = issue_ok && (req0_valid || req1_valid);
        beat_go  = (state == S_WBURST) && !wdf_af_q && !rst_q;
        tag_push = (state == S_RADDR) && !rst_q;
        ret_go   = read_data_valid && !tag_empty && !rst_q;
        tag_pop  = ret_go && ((rcnt + 3'd1) == burst_length_div2);
    end

    assign req0_ack   = gnt_any && !pick1;
    assign req1_ack   = gnt_any && pick1;
    assign req0_wbeat = beat_go && !sel_q;
    assign req1_wbeat = beat_go && sel_q;

    always_ff @(posedge clk) begin
        if (rst_q) begin
            state         <= S_IDLE;
            sel_q         <= 1'b0;
            addr_q        <= '0;
            wcnt          <= '0;
            rcnt          <= '0;
`ifndef DDR2_ARB_FIXED_PRIO_EN
            rr_ptr        <= 1'b0;
`endif
            app_af_addr   <= '0;
            app_af_wren   <= 1'b0;
            app_wdf_data  <= '0;
            app_mask_data <= '0;
            app_wdf_wren  <= 1'b0;
            rd_data       <= '0;
            rd_valid0     <= 1'b0;
            rd_valid1     <= 1'b0;
            tag_overflow  <= 1'b0;
        end else begin
            app_af_wren  <= 1'b0;
            app_wdf_wren <= 1'b0;
            rd_valid0    <= 1'b0;
            rd_valid1    <= 1'b0;
            rd_data      <= read_data_fifo_out;

            case (state)
                S_IDLE: begin
                    if (gnt_any) begin
                        sel_q  <= pick1;
                        addr_q <= pick1 ? req1_addr : req0_addr;
                        wcnt   <= burst_length_div2;
                        state  <= (pick1 ? req1_rd : req0_rd) ? S_RADDR : S_WBURST;
`ifndef DDR2_ARB_FIXED_PRIO_EN
                        rr_ptr <= !pick1;
`endif
                    end
                end
                S_WBURST: begin
                    if (beat_go) begin
                        app_wdf_wren  <= 1'b1;
                        app_wdf_data  <= sel_q ? req1_wdata : req0_wdata;
                        app_mask_data <= sel_q ? req1_wmask : req0_wmask;
                        wcnt          <= wcnt - 3'd1;
                        if (wcnt == 3'd1) begin
                            app_af_wren <= 1'b1;
                            app_af_addr <= {{(ADDR_W-35){1'b0}}, CMD_WR, addr_q};
                            state       <= S_IDLE;
                        end
                    end
                end
                S_RADDR: begin
                    app_af_wren <= 1'b1;
                    app_af_addr <= {{(ADDR_W-35){1'b0}}, CMD_RD, addr_q};
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // beats arriving with nothing outstanding are dropped and flagged
            if (ret_go) begin
                rd_valid0 <= !tag_head;
                rd_valid1 <= tag_head;
                rcnt      <= tag_pop ? 3'd0 : rcnt + 3'd1;
            end else if (read_data_valid) begin
                tag_overflow <= 1'b1;
            end
        end
    end

    ddr2_tag_fifo_0 #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (rst_q),
        .push  (tag_push),
        .din   (sel_q),
        .pop   (tag_pop),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty)
    );

endmodule

// File: tb/tb_ddr2_port_arbiter_0.sv
// Self-checking bench for ddr2_port_arbiter_0: cycle-level reference model plus
// directed scenarios with literal expectations (honours DDR2_ARB_FIXED_PRIO_EN).
module tb_ddr2_port_arbiter_0;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         init_done = 1'b1;
    logic         af_almost_full = 1'b0;
    logic         wdf_almost_full = 1'b0;
    logic [2:0]   burst_length_div2 = 3'd2;
    logic         req0_valid = 1'b0, req0_rd = 1'b0;
    logic [31:0]  req0_addr = '0;
    logic         req1_valid = 1'b0, req1_rd = 1'b0;
    logic [31:0]  req1_addr = '0;
    logic [143:0] req0_wdata, req1_wdata;
    logic [17:0]  req0_wmask, req1_wmask;
    logic         req0_ack, req1_ack, req0_wbeat, req1_wbeat;
    logic [35:0]  app_af_addr;
    logic         app_af_wren, app_wdf_wren;
    logic [143:0] app_wdf_data;
    logic [17:0]  app_mask_data;
    logic         read_data_valid = 1'b0;
    logic [143:0] read_data_fifo_out = '0;
    logic [143:0] rd_data;
    logic         rd_valid0, rd_valid1, tag_overflow;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    ddr2_port_arbiter_0 dut (
        .clk(clk), .reset(reset), .init_done(init_done),
        .af_almost_full(af_almost_full), .wdf_almost_full(wdf_almost_full),
        .burst_length_div2(burst_length_div2),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_addr(req0_addr), .req0_ack(req0_ack),
        .req0_wdata(req0_wdata), .req0_wmask(req0_wmask), .req0_wbeat(req0_wbeat),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_addr(req1_addr), .req1_ack(req1_ack),
        .req1_wdata(req1_wdata), .req1_wmask(req1_wmask), .req1_wbeat(req1_wbeat),
        .app_af_addr(app_af_addr), .app_af_wren(app_af_wren),
        .app_wdf_data(app_wdf_data), .app_mask_data(app_mask_data), .app_wdf_wren(app_wdf_wren),
        .read_data_valid(read_data_valid), .read_data_fifo_out(read_data_fifo_out),
        .rd_data(rd_data), .rd_valid0(rd_valid0), .rd_valid1(rd_valid1), .tag_overflow(tag_overflow)
    );

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [143:0] wpat(input int p, input int i);
        return {8'(8'hA0 + p), 104'd0, 32'(i)};
    endfunction

    // FWFT write-beat sources: advance one beat each time the DUT consumes one
    int widx0 = 0, widx1 = 0;
    bit s0, s1;
    always_comb begin
        req0_wdata = wpat(0, widx0);
        req1_wdata = wpat(1, widx1);
        req0_wmask = 18'(widx0 * 2 + 1);
        req1_wmask = 18'(widx1 * 2 + 2);
    end
    always begin
        @(negedge clk); #1;
        s0 = req0_wbeat; s1 = req1_wbeat;
        @(posedge clk); #1;
        if (s0) widx0++;
        if (s1) widx1++;
    end

    // reference model: what the arbiter must do, tracked per cycle
    int m_mode = 0;              // 0 idle, 1 write burst, 2 read address
    int m_who = 0, m_left = 0, m_ret = 0;
    int tagq[$];
    logic [31:0] m_addr = '0;
    logic m_ptr = 0, m_waf = 0, m_rq = 1;
    logic e_af_wren = 0, e_wdf_wren = 0, e_rv0 = 0, e_rv1 = 0, e_ovf = 0;
    logic [35:0] e_af_addr = '0;
    logic [143:0] e_wdf_data = '0, e_rd_data = '0;
    logic [17:0] e_mask = '0;
    logic x_a0, x_a1, x_w0, x_w1, ok;
    int win;

    // logs for the directed literal checks
    int ackq[$];
    int rdq[$];
    logic [143:0] wdq[$];
    int wdt[$];
    logic [35:0] afq[$];
    int af_coinc[$];

    always @(negedge clk) begin
        cyc++;
        ok = !m_rq && m_mode == 0 && init_done && !m_waf && !af_almost_full && tagq.size() < 16;
`ifdef DDR2_ARB_FIXED_PRIO_EN
        win = req0_valid ? 0 : 1;
`else
        win = (req0_valid && req1_valid) ? int'(m_ptr) : (req0_valid ? 0 : 1);
`endif
        x_a0 = ok && req0_valid && win == 0;
        x_a1 = ok && req1_valid && win == 1;
        x_w0 = !m_rq && m_mode == 1 && !m_waf && m_who == 0;
        x_w1 = !m_rq && m_mode == 1 && !m_waf && m_who == 1;

        if (chk_en) begin
            chk("ack0", req0_ack, x_a0);
            chk("ack1", req1_ack, x_a1);
            chk("wbeat0", req0_wbeat, x_w0);
            chk("wbeat1", req1_wbeat, x_w1);
            chk("af_wren", app_af_wren, e_af_wren);
            chk("af_addr", app_af_addr, e_af_addr);
            chk("wdf_wren", app_wdf_wren, e_wdf_wren);
            chk("wdf_data", app_wdf_data, e_wdf_data);
            chk("wdf_mask", app_mask_data, e_mask);
            chk("rd_valid0", rd_valid0, e_rv0);
            chk("rd_valid1", rd_valid1, e_rv1);
            chk("rd_data", rd_data, e_rd_data);
            chk("tag_overflow", tag_overflow, e_ovf);
        end

        if (req0_ack) ackq.push_back(0);
        if (req1_ack) ackq.push_back(1);
        if (rd_valid0) rdq.push_back(0);
        if (rd_valid1) rdq.push_back(1);
        if (app_wdf_wren) begin wdq.push_back(app_wdf_data); wdt.push_back(cyc); end
        if (app_af_wren) begin afq.push_back(app_af_addr); af_coinc.push_back(int'(app_wdf_wren)); end

        // advance the model across the coming rising edge
        if (m_rq) begin
            m_mode = 0; m_ret = 0; m_ptr = 0; tagq.delete();
            e_af_wren = 0; e_wdf_wren = 0; e_rv0 = 0; e_rv1 = 0; e_ovf = 0;
            e_af_addr = '0; e_wdf_data = '0; e_mask = '0; e_rd_data = '0;
        end else begin
            e_af_wren = 0; e_wdf_wren = 0; e_rv0 = 0; e_rv1 = 0;
            e_rd_data = read_data_fifo_out;
            if (read_data_valid) begin
                if (tagq.size() == 0) e_ovf = 1;
                else begin
                    e_rv0 = (tagq[0] == 0);
                    e_rv1 = (tagq[0] == 1);
                    m_ret++;
                    if (m_ret == int'(burst_length_div2)) begin
                        void'(tagq.pop_front());
                        m_ret = 0;
                    end
                end
            end
            if (x_a0 || x_a1) begin
                m_who  = x_a1 ? 1 : 0;
                m_addr = x_a1 ? req1_addr : req0_addr;
                m_left = int'(burst_length_div2);
                m_mode = (x_a1 ? req1_rd : req0_rd) ? 2 : 1;
                m_ptr  = x_a1 ? 1'b0 : 1'b1;
            end else if (x_w0 || x_w1) begin
                e_wdf_wren = 1;
                e_wdf_data = x_w1 ? req1_wdata : req0_wdata;
                e_mask     = x_w1 ? req1_wmask : req0_wmask;
                m_left--;
                if (m_left == 0) begin
                    e_af_wren = 1;
                    e_af_addr = {4'b0000, m_addr};
                    m_mode = 0;
                end
            end else if (!m_rq && m_mode == 2) begin
                e_af_wren = 1;
                e_af_addr = {4'b0001, m_addr};
                tagq.push_back(m_who);
                m_mode = 0;
            end
        end
        m_waf = wdf_almost_full;
        m_rq  = reset;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        ackq.delete(); rdq.delete(); wdq.delete(); wdt.delete(); afq.delete(); af_coinc.delete();
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (3) tick();
        reset = 0;
        repeat (2) tick();
    endtask

    task automatic issue(input int port, input bit rd, input logic [31:0] addr);
        bit got;
        got = 0;
        if (port == 0) begin req0_valid = 1; req0_rd = rd; req0_addr = addr; end
        else begin req1_valid = 1; req1_rd = rd; req1_addr = addr; end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if ((port == 0 && req0_ack) || (port == 1 && req1_ack)) got = 1;
            @(posedge clk); #1;
            if (got) break;
        end
        if (port == 0) req0_valid = 0; else req1_valid = 0;
        chk("ack_seen", got, 1);
    endtask

    int base, gap, n;

    initial begin
        repeat (4) tick();
        reset = 0;
        repeat (2) tick();
        chk_en = 1;

        // reset state
        @(negedge clk); #1;
        chk("rst_af_wren", app_af_wren, 0);
        chk("rst_wdf_wren", app_wdf_wren, 0);
        chk("rst_af_addr", app_af_addr, 0);
        chk("rst_ovf", tag_overflow, 0);
        chk("rst_rv", {rd_valid1, rd_valid0}, 0);
        tick();

        // write, burst 2, to 0x40
        clear_logs(); base = widx0;
        issue(0, 0, 32'h40);
        repeat (5) tick();
        chk("w2_acks", ackq.size(), 1);
        chk("w2_beats", wdq.size(), 2);
        if (wdq.size() == 2) begin
            chk("w2_d0", wdq[0], wpat(0, base));
            chk("w2_d1", wdq[1], wpat(0, base + 1));
        end
        chk("w2_afn", afq.size(), 1);
        if (afq.size() == 1) begin
            chk("w2_addr", afq[0], 36'h0_0000_0040);
            chk("w2_coinc", af_coinc[0], 1);
        end

        // back-pressure mid-burst, burst 4
        burst_length_div2 = 3'd4;
        clear_logs(); base = widx0;
        issue(0, 0, 32'h80);
        tick();
        wdf_almost_full = 1; af_almost_full = 1;
        repeat (5) tick();
        wdf_almost_full = 0; af_almost_full = 0;
        repeat (10) tick();
        chk("bp_beats", wdq.size(), 4);
        if (wdq.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("bp_order", wdq[i], wpat(0, base + i));
            gap = wdt[2] - wdt[1];
            chk("bp_delayed", gap >= 5, 1);
        end
        chk("bp_afn", afq.size(), 1);
        if (afq.size() == 1) begin
            chk("bp_addr", afq[0], 36'h0_0000_0080);
            chk("bp_coinc", af_coinc[0], 1);
        end
        burst_length_div2 = 3'd2;

        // read steering: req1 then req0, four return beats
        clear_logs();
        issue(1, 1, 32'h100);
        issue(0, 1, 32'h200);
        repeat (2) tick();
        for (int k = 0; k < 4; k++) begin
            read_data_valid = 1; read_data_fifo_out = 144'(32'h55 + k);
            tick();
        end
        read_data_valid = 0;
        repeat (3) tick();
        chk("rs_afn", afq.size(), 2);
        if (afq.size() == 2) begin
            chk("rs_addr0", afq[0], 36'h1_0000_0100);
            chk("rs_addr1", afq[1], 36'h1_0000_0200);
        end
        chk("rs_n", rdq.size(), 4);
        if (rdq.size() == 4) begin
            chk("rs_b1", rdq[0], 1);
            chk("rs_b2", rdq[1], 1);
            chk("rs_b3", rdq[2], 0);
            chk("rs_b4", rdq[3], 0);
        end
        chk("rs_ovf", tag_overflow, 0);

        // arbitration with both requesters reading continuously
        do_reset(); clear_logs();
        req0_valid = 1; req0_rd = 1; req0_addr = 32'h300;
        req1_valid = 1; req1_rd = 1; req1_addr = 32'h400;
        n = 0;
        while (ackq.size() < 4 && n < 40) begin
            @(negedge clk); #1;
            n++;
            if (ackq.size() < 4) tick();
        end
        tick();
        req0_valid = 0; req1_valid = 0;
        repeat (3) tick();
        chk("rr_n", ackq.size(), 4);
        if (ackq.size() == 4) begin
`ifdef DDR2_ARB_FIXED_PRIO_EN
            for (int i = 0; i < 4; i++) chk("fp_seq", ackq[i], 0);
`else
            chk("rr_0", ackq[0], 0);
            chk("rr_1", ackq[1], 1);
            chk("rr_2", ackq[2], 0);
            chk("rr_3", ackq[3], 1);
`endif
        end

        // tag FIFO full: 16 outstanding reads block the 17th
        do_reset(); clear_logs();
        req0_valid = 1; req0_rd = 1; req0_addr = 32'h500;
        repeat (45) tick();
        chk("full_16", ackq.size(), 16);
        for (int k = 0; k < 2; k++) begin
            read_data_valid = 1; read_data_fifo_out = 144'(32'h77 + k);
            tick();
        end
        read_data_valid = 0;
        n = 0;
        while (ackq.size() < 17 && n < 20) begin tick(); n++; end
        req0_valid = 0;
        repeat (3) tick();
        chk("full_17", ackq.size(), 17);

        // stray return beat with nothing outstanding
        do_reset(); clear_logs();
        read_data_valid = 1; read_data_fifo_out = 144'h99;
        tick();
        read_data_valid = 0;
        tick();
        @(negedge clk); #1;
        chk("ovf_set", tag_overflow, 1);
        chk("ovf_norv", rdq.size(), 0);
        tick();

        // init_done low gates all issue
        clear_logs();
        init_done = 0;
        req0_valid = 1; req0_rd = 0; req0_addr = 32'h600;
        repeat (10) tick();
        req0_valid = 0;
        init_done = 1;
        tick();
        chk("gate_noack", ackq.size(), 0);

        // reset in the middle of a write burst
        burst_length_div2 = 3'd4;
        issue(0, 0, 32'hC0);
        reset = 1;
        repeat (2) tick();
        @(negedge clk); #1;
        chk("mr_wdf_wren", app_wdf_wren, 0);
        chk("mr_af_wren", app_af_wren, 0);
        chk("mr_wdf_data", app_wdf_data, 0);
        chk("mr_ovf", tag_overflow, 0);
        chk("mr_wbeat", req0_wbeat, 0);
        tick();
        reset = 0;
        burst_length_div2 = 3'd2;
        repeat (2) tick();
        clear_logs();
        issue(1, 1, 32'h700);
        repeat (3) tick();
        chk("mr_idle_afn", afq.size(), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ddr2_port_arbiter_0.md
# ddr2_port_arbiter_0

Two-port command arbiter for the DDR2 user interface. It shares the controller's address FIFO (app_af) and write-data FIFO (app_wdf) between two independent requesters. It honours the almost-full back-pressure and `init_done`, and steers returning read bursts to the requester that issued them using an in-order tag FIFO. It sits between the application-side masters (traffic generator, host bridge) and the DDR2 controller top.

## Interface
- `ADDR_W`, 36: width of `app_af_addr`; bits [34:32] carry the command (000 write, 001 read), bits [31:0] the address.
- `DATA_W`, 144: beat width, equal to 2×DQ_WIDTH.
- `MASK_W`, 18: mask width, equal to 2×DM_WIDTH.
- `TAG_DEPTH`, 16: outstanding-read tag FIFO depth; must be a power of two.
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` in 1: the single clock.
  - `reset` in 1: synchronous, active-high; registered once internally before use.
- `init_done` in 1: controller calibration complete.
- `af_almost_full` in 1, `wdf_almost_full` in 1: controller FIFO back-pressure.
- `burst_length_div2` in 3: beats per burst (2 or 4).
- `req0_valid`/`req1_valid` in 1: command pending.
- `req0_rd`/`req1_rd` in 1: 1 = read, 0 = write.
- `req0_addr`/`req1_addr` in 32: burst address.
- `req0_ack`/`req1_ack` out 1: one-cycle pulse when the command is taken.
- `req0_wdata`/`req1_wdata` in DATA_W, `req0_wmask`/`req1_wmask` in MASK_W: current write beat, first-word-fall-through.
- `req0_wbeat`/`req1_wbeat` out 1: beat consumed this cycle; the requester advances to the next beat.
- `app_af_addr` out ADDR_W, `app_af_wren` out 1: address FIFO write.
- `app_wdf_data` out DATA_W, `app_mask_data` out MASK_W, `app_wdf_wren` out 1: data FIFO write.
- `read_data_valid` in 1, `read_data_fifo_out` in DATA_W: returning read beats.
- `rd_data` out DATA_W: registered copy of `read_data_fifo_out`.
- `rd_valid0`/`rd_valid1` out 1: beat belongs to requester 0 or 1.
- `tag_overflow` out 1: sticky error flag.

## Operation
- States are IDLE, WBURST and RADDR.
- IDLE:
  - Issue is allowed only if `init_done`=1, registered `wdf_almost_full`=0, `af_almost_full`=0 and the tag FIFO is not full.
  - When allowed, pick a requester (see Configuration) and pulse its `ack`.
  - A write goes to WBURST; the write beat counter loads `burst_length_div2`.
  - A read goes to RADDR.
- WBURST: each cycle with registered `wdf_almost_full`=0:
  - pulse `reqN_wbeat`;
  - register the beat to `app_wdf_*` with `app_wdf_wren`=1;
  - decrement the beat counter.
- WBURST, last beat (counter = 1):
  - also write `app_af_addr` = {1'b0, 3'b000, addr} with `app_af_wren`=1;
  - return to IDLE.
- WBURST stall: while `wdf_almost_full` is high, no beat is consumed and the counter holds. `af_almost_full` is ignored mid-burst; the address of an in-flight burst always completes.
- RADDR:
  - write `app_af_addr` = {1'b0, 3'b001, addr} with `app_af_wren`=1;
  - push the requester id into the tag FIFO;
  - return to IDLE.
- Read return:
  - each `read_data_valid` beat asserts `rd_validN` for the head tag;
  - a return beat counter counts `burst_length_div2` beats, then pops the tag.
- Simultaneous tag push and pop keeps the occupancy unchanged.
- `read_data_valid` with the tag FIFO empty sets `tag_overflow` and drops the beat. `tag_overflow` is sticky until reset.
- Reset values:
  - all outputs 0 and state IDLE;
  - tag FIFO empty and counters 0;
  - the round-robin pointer favours requester 0.
- Reset mid-burst aborts the burst; a partial burst is the requester's problem.

## Timing
- Ack: `reqN_ack` is asserted in the first IDLE cycle after `reqN_valid` is seen, provided issue is allowed.
- Write data: first `app_wdf_wren` one cycle after the ack. `app_wdf_wren` and `app_af_wren` are registered outputs.
- Address latency, read: `app_af_wren` one cycle after the ack.
- Address latency, write: `app_af_wren` coincident with the last `app_wdf_wren`.
- Throughput: the minimum spacing between acks is burst_len+1 cycles for writes and 2 cycles for reads.
- Read return: `rd_validN` and `rd_data` one cycle after `read_data_valid`.
- Wrap: the tag FIFO pointers wrap modulo TAG_DEPTH.

## Configuration
- `DDR2_ARB_FIXED_PRIO_EN` defined: requester 0 always wins ties; requester 1 is served only when requester 0 is idle.
- Not defined: round-robin. After a grant, the pointer moves to the other requester. A lone requester is granted back-to-back.

## Structure
- Shared package `ddr2_arb_pkg`:
  - command encodings CMD_WR = 3'b000 and CMD_RD = 3'b001;
  - state localparams;
  - the tag width constant clog2(TAG_DEPTH).
- Sub-module `ddr2_tag_fifo_0`: synchronous FIFO, 1-bit wide and TAG_DEPTH deep, with `full`/`empty` outputs.

## Test plan
- Write, burst_len 2: `req0` write to 0x40 → two `app_wdf_wren` beats, then `app_af_addr` = 0x0_0000_0040 with cmd 000 on the second beat; `req0_ack` pulses once.
- Round robin: both requesters hold read requests continuously → `app_af_wren` alternates 0,1,0,1 (no `DDR2_ARB_FIXED_PRIO_EN`). With the macro defined → only `req0` is served.
- Back-pressure: write with burst_len 4 and `wdf_almost_full` raised after beat 2 for 5 cycles → beats 3–4 are delayed, data order is intact, and the address follows the last beat.
- Read steering: `req1` read then `req0` read, followed by 4 valid beats (burst_len 2) → `rd_valid1` on beats 1–2 and `rd_valid0` on beats 3–4.
- Tag full: TAG_DEPTH=16 with 16 reads outstanding → no 17th ack until a burst returns. A stray `read_data_valid` with no reads outstanding → `tag_overflow`=1.
- Gating and reset: `init_done`=0 → no acks. Reset asserted mid-write → the next cycle shows all outputs at 0 and state IDLE.
